// File: rtl/dmem_resp_pkg.sv
// Shared load/store constants: data width, access-size encodings, responder FSM states.
// Pure declarations, no logic.
// Imported by the responder, its alignment helper and the CPU load/store path.
package dmem_resp_pkg;

  localparam int WORD = 32;

  // Access size encoding carried on req_size
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_resp_if.sv
// Load/store request and response channels between CPU (master) and memory (slave).
// No latency of its own.
// Both channels use valid/ready; each side may stall via its ready.
interface dmem_resp_if;
  import dmem_resp_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [WORD-1:0] req_addr;
  logic [WORD-1:0] req_wdata;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic            resp_valid;
  logic            resp_ready;
  logic [WORD-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_resp_lsu_align.sv
// Lane alignment: byte enables, replicated store data, error detection, load extract/extend.
// Purely combinational, zero latency.
// No handshake; the caller decides when its outputs are used.
module lsu_align
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic [WORD-1:0] addr_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [WORD-1:0] rword_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [3:0]      be_o,
  output logic [WORD-1:0] wdata_o,
  output logic [WORD-1:0] rdata_o,
  output logic            err_o
);

  localparam logic [WORD-3:0] DEPTH_W = (WORD-2)'(DEPTH);

  logic [WORD-1:0] shifted;
  logic [3:0]      be;
  logic [WORD-1:0] ext;
  logic            misal;
  logic            oor;

  // Bring the addressed lane down to bit 0 so byte and half extraction share one path
  assign shifted = rword_i >> {addr_i[1:0], 3'b000};
  assign oor     = (addr_i[WORD-1:2] >= DEPTH_W);

  // Per-size lane enables, store replication and load extension
  always_comb begin
    be      = 4'b0000;
    wdata_o = '0;
    ext     = '0;
    misal   = 1'b0;
    case (size_e'(size_i))
      SZ_BYTE: begin
        be      = 4'b0001 << addr_i[1:0];
        wdata_o = {4{wdata_i[7:0]}};
        ext     = unsigned_i ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misal   = addr_i[0];
        be      = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        ext     = unsigned_i ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        misal   = (addr_i[1:0] != 2'b00);
        be      = 4'b1111;
        wdata_o = wdata_i;
        ext     = rword_i;
      end
      default: misal = 1'b1;
    endcase
  end

  // Any error kills the write and zeroes the returned data
  assign err_o   = misal | oor;
  assign be_o    = err_o ? 4'b0000 : be;
  assign rdata_o = err_o ? '0 : ext;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one load/store outstanding, completion LATENCY cycles after accept.
// Response appears LATENCY edges after the accept edge (same edge when LATENCY == 1).
// resp_ready low holds the response indefinitely; req_ready is high only in IDLE.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic        clk,
  input logic        rst_n,
  dmem_resp_if.slave mem_if
);

  localparam int AW = $clog2(DEPTH);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, uns_q;
  logic [WORD-1:0] addr_q, wdata_q;
  logic [1:0]      size_q;
  logic [WORD-1:0] rdata_q;
  logic            err_q;
  logic [WORD-1:0] mem_q [DEPTH];

  logic            accept, commit;
  logic            a_wr, a_uns;
  logic [WORD-1:0] a_addr, a_wdata;
  logic [1:0]      a_size;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [WORD-1:0] wsh, ext;
  logic            err;

  assign accept = mem_if.req_valid && (state_q == ST_IDLE);

  // With LATENCY == 1 the access happens on the accept edge, so it must see the live request
  assign a_wr    = (state_q == ST_IDLE) ? mem_if.req_write    : wr_q;
  assign a_addr  = (state_q == ST_IDLE) ? mem_if.req_addr     : addr_q;
  assign a_wdata = (state_q == ST_IDLE) ? mem_if.req_wdata    : wdata_q;
  assign a_size  = (state_q == ST_IDLE) ? mem_if.req_size     : size_q;
  assign a_uns   = (state_q == ST_IDLE) ? mem_if.req_unsigned : uns_q;
  assign idx     = a_addr[AW+1:2];

  // Reset gating keeps a held-in-reset requester from writing through the LATENCY == 1 path
  assign commit = rst_n && (((state_q == ST_IDLE) && accept && (LATENCY == 1)) ||
                            ((state_q == ST_WAIT) && (cnt_q == 4'd0)));

  lsu_align #(.DEPTH(DEPTH)) u_align (
    .addr_i     (a_addr),
    .wdata_i    (a_wdata),
    .rword_i    (mem_q[idx]),
    .size_i     (a_size),
    .unsigned_i (a_uns),
    .be_o       (be),
    .wdata_o    (wsh),
    .rdata_o    (ext),
    .err_o      (err)
  );

  // State and latency counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: IDLE -> WAIT (or RESP) on accept, WAIT -> RESP at count 0, RESP -> IDLE on handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: if (mem_if.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs come from state alone
  always_comb begin
    mem_if.req_ready  = (state_q == ST_IDLE);
    mem_if.resp_valid = (state_q == ST_RESP);
    mem_if.resp_rdata = rdata_q;
    mem_if.resp_err   = err_q;
  end

  // Capture the request at accept so the requester may change its inputs afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
    end else if (accept) begin
      wr_q    <= mem_if.req_write;
      addr_q  <= mem_if.req_addr;
      wdata_q <= mem_if.req_wdata;
      size_q  <= mem_if.req_size;
      uns_q   <= mem_if.req_unsigned;
    end
  end

  // Response data/error are captured once at commit and held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= a_wr ? '0 : ext;
      err_q   <= err;
    end
  end

  // Storage: not reset; stores write only enabled lanes
  always_ff @(posedge clk) begin
    if (commit && a_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_resp_if ifa ();
  dmem_resp_if ifb ();

  dmem_resp #(.DEPTH(1024), .LATENCY(2)) dut_a (.clk(clk), .rst_n(rst_n), .mem_if(ifa));
  dmem_resp #(.DEPTH(1024), .LATENCY(1)) dut_b (.clk(clk), .rst_n(rst_n), .mem_if(ifb));

  // Results of the most recent transaction
  logic [31:0] rd;
  logic        er, rr_low, rdy_after;
  int          lat, acc;
  logic        s_vld, s_rdy, s_er;
  logic [31:0] s_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic u, input logic rr);
    if (!b) begin
      ifa.req_valid = v; ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = wd;
      ifa.req_size = sz; ifa.req_unsigned = u; ifa.resp_ready = rr;
    end else begin
      ifb.req_valid = v; ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = wd;
      ifb.req_size = sz; ifb.req_unsigned = u; ifb.resp_ready = rr;
    end
  endtask

  task automatic sample(input bit b);
    if (!b) begin
      s_vld = ifa.resp_valid; s_rdy = ifa.req_ready; s_rd = ifa.resp_rdata; s_er = ifa.resp_err;
    end else begin
      s_vld = ifb.resp_valid; s_rdy = ifb.req_ready; s_rd = ifb.resp_rdata; s_er = ifb.resp_err;
    end
  endtask

  // One full transaction with resp_ready high; called and returns at a falling edge
  task automatic go(input bit b, input logic w, input logic [31:0] a, input logic [31:0] wd,
                    input logic [1:0] sz, input logic u);
    bit got;
    got = 1'b0;
    drive(b, 1'b1, w, a, wd, sz, u, 1'b1);
    @(posedge clk);
    #1;
    acc = cyc;
    // Scramble request inputs: the responder must use what it latched
    drive(b, 1'b0, ~w, $urandom, $urandom, 2'($urandom_range(0, 3)), ~u, 1'b1);
    lat = 0;
    rr_low = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      sample(b);
      if (s_rdy) rr_low = 1'b0;
      if (s_vld) begin
        got = 1'b1;
        rd  = s_rd;
        er  = s_er;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $error("FAIL timeout addr=%h observed=no resp_valid expected=resp_valid within 40 cycles", a);
    end
    @(posedge clk);
    @(negedge clk);
    sample(b);
    rdy_after = s_rdy;
  endtask

  initial begin
    int acc0;
    bit got;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(ifa.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(ifa.resp_valid), 32'd0);
    chk("rst_rdata", ifa.resp_rdata, 32'h0);
    chk("rst_err", 32'(ifa.resp_err), 32'd0);
    rst_n = 1'b1;

    // Word store then load, LATENCY=2
    go(0, 1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_rdy_low", 32'(rr_low), 32'd1);
    chk("sw_rdy_after", 32'(rdy_after), 32'd1);
    go(0, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);
    chk("lw_rdy_low", 32'(rr_low), 32'd1);

    // Sub-word loads
    go(0, 1'b1, 32'h20, 32'h80FF7F01, SZ_WORD, 1'b0);
    go(0, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b0); chk("lb21", rd, 32'h0000007F);
    go(0, 1'b0, 32'h22, 32'h0, SZ_BYTE, 1'b0); chk("lb22", rd, 32'hFFFFFFFF);
    go(0, 1'b0, 32'h23, 32'h0, SZ_BYTE, 1'b1); chk("lbu23", rd, 32'h00000080);
    go(0, 1'b0, 32'h22, 32'h0, SZ_HALF, 1'b0); chk("lh22", rd, 32'hFFFF80FF);
    go(0, 1'b0, 32'h22, 32'h0, SZ_HALF, 1'b1); chk("lhu22", rd, 32'h000080FF);
    go(0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b1); chk("lw20_uns", rd, 32'h80FF7F01);

    // Back-pressure on lw 0x20; a store offered meanwhile must be ignored
    drive(0, 1'b1, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ifa.resp_valid) got = 1'b1;
    end
    chk("bp_reached", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, SZ_WORD, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      sample(0);
      chk("bp_valid", 32'(s_vld), 32'd1);
      chk("bp_rdata", s_rd, 32'h80FF7F01);
      chk("bp_err", 32'(s_er), 32'd0);
      chk("bp_req_ready", 32'(s_rdy), 32'd0);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_rel_req_ready", 32'(ifa.req_ready), 32'd1);
    chk("bp_rel_valid", 32'(ifa.resp_valid), 32'd0);
    go(0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0); chk("bp_store_ignored", rd, 32'h80FF7F01);

    // Store lanes: byte and half right-aligned data
    go(0, 1'b1, 32'h21, 32'h123456AB, SZ_BYTE, 1'b0);
    go(0, 1'b1, 32'h22, 32'hCAFEBEEF, SZ_HALF, 1'b0);
    go(0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0); chk("sb_sh_lanes", rd, 32'hBEEFAB01);

    // Errors
    go(0, 1'b1, 32'h30, 32'h55667788, SZ_WORD, 1'b0);
    go(0, 1'b1, 32'h31, 32'h00001234, SZ_HALF, 1'b0);
    chk("sh31_err", 32'(er), 32'd1); chk("sh31_rdata", rd, 32'h0);
    go(0, 1'b0, 32'h30, 32'h0, SZ_WORD, 1'b0);
    chk("lw30_unchanged", rd, 32'h55667788); chk("lw30_err", 32'(er), 32'd0);
    go(0, 1'b0, 32'h32, 32'h0, SZ_WORD, 1'b0);
    chk("lw32_err", 32'(er), 32'd1); chk("lw32_rdata", rd, 32'h0);
    go(0, 1'b0, 32'h30, 32'h0, 2'b11, 1'b0);
    chk("sz11_err", 32'(er), 32'd1); chk("sz11_rdata", rd, 32'h0);
    go(0, 1'b0, 32'h1000, 32'h0, SZ_WORD, 1'b0);
    chk("lw1000_err", 32'(er), 32'd1); chk("lw1000_rdata", rd, 32'h0);
    go(0, 1'b1, 32'hFFC, 32'h0BADF00D, SZ_WORD, 1'b0);
    go(0, 1'b0, 32'hFFC, 32'h0, SZ_WORD, 1'b0);
    chk("lwFFC_rdata", rd, 32'h0BADF00D); chk("lwFFC_err", 32'(er), 32'd0);

    // Reset during WAIT abandons the store
    go(0, 1'b1, 32'h40, 32'h11111111, SZ_WORD, 1'b0);
    go(0, 1'b0, 32'h40, 32'h0, SZ_WORD, 1'b0); chk("lw40_pre", rd, 32'h11111111);
    drive(0, 1'b1, 1'b1, 32'h40, 32'hAAAAAAAA, SZ_WORD, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0, 1'b1);
    @(negedge clk);
    chk("wait_req_ready", 32'(ifa.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstw_req_ready", 32'(ifa.req_ready), 32'd1);
    chk("rstw_valid", 32'(ifa.resp_valid), 32'd0);
    chk("rstw_rdata", ifa.resp_rdata, 32'h0);
    chk("rstw_err", 32'(ifa.resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    go(0, 1'b0, 32'h40, 32'h0, SZ_WORD, 1'b0); chk("lw40_post", rd, 32'h11111111);

    // LATENCY=1 instance: back-to-back, one transaction every 2 cycles
    go(1, 1'b1, 32'h100, 32'hCAFEF00D, SZ_WORD, 1'b0);
    chk("l1_sw_lat", 32'(lat), 32'd0);
    acc0 = acc;
    go(1, 1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0);
    chk("l1_lw_rdata", rd, 32'hCAFEF00D);
    chk("l1_period1", 32'(acc - acc0), 32'd2);
    acc0 = acc;
    go(1, 1'b1, 32'h104, 32'h01234567, SZ_WORD, 1'b0);
    chk("l1_period2", 32'(acc - acc0), 32'd2);
    acc0 = acc;
    go(1, 1'b0, 32'h105, 32'h0, SZ_BYTE, 1'b0);
    chk("l1_lb_rdata", rd, 32'h00000045);
    chk("l1_period3", 32'(acc - acc0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
